// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes, flag bit positions, requester ids and stage records.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 7;

  localparam logic [OP_W-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_OP_SHL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_OP_SHR  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_OP_PASS = 4'b0111;

  // Flag vector bit positions
  localparam int FLG_C  = 0;  // carry (ADD) / borrow (SUB)
  localparam int FLG_Z  = 1;  // result is zero
  localparam int FLG_N  = 2;  // result sign bit
  localparam int FLG_V  = 3;  // signed overflow
  localparam int FLG_P  = 4;  // even parity of low result byte
  localparam int FLG_AF = 5;  // carry/borrow out of bit 3
  localparam int FLG_EQ = 6;  // operands equal

  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_ADDR = 1'b1;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } s1_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] out;
    logic [FLAG_W-1:0] flags;
  } s2_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by the execute stage and the address/string unit.
module alu
  import alu_pkg::*;
(
  output logic [DATA_W-1:0] out,
  output logic [FLAG_W-1:0] flags,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Result and flag generation; carry-style flags only meaningful for ADD/SUB
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    out   = '0;
    flags = '0;
    unique case (op)
      ALU_OP_ADD: begin
        out           = sum[DATA_W-1:0];
        flags[FLG_C]  = sum[DATA_W];
        flags[FLG_V]  = (a[DATA_W-1] ~^ b[DATA_W-1]) & (out[DATA_W-1] ^ a[DATA_W-1]);
        flags[FLG_AF] = a[4] ^ b[4] ^ out[4];
      end
      ALU_OP_SUB: begin
        out           = diff[DATA_W-1:0];
        flags[FLG_C]  = diff[DATA_W];
        flags[FLG_V]  = (a[DATA_W-1] ^ b[DATA_W-1]) & (out[DATA_W-1] ^ a[DATA_W-1]);
        flags[FLG_AF] = a[4] ^ b[4] ^ out[4];
      end
      ALU_OP_AND:  out = a & b;
      ALU_OP_OR:   out = a | b;
      ALU_OP_XOR:  out = a ^ b;
      ALU_OP_SHL:  out = a << b[SH_W-1:0];
      ALU_OP_SHR:  out = a >> b[SH_W-1:0];
      ALU_OP_PASS: out = b;
      default:     out = '0;
    endcase
    flags[FLG_Z]  = (out == '0);
    flags[FLG_N]  = out[DATA_W-1];
    flags[FLG_P]  = ~^out[7:0];
    flags[FLG_EQ] = (a == b);
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grant from valids and pointer, pointer moves past the winner on accept.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       rr_ptr_nxt_o
);

  // Grant never looks at ready, so the ready path stays loop-free
  always_comb begin
    grant_o = valid_i;
    if (&valid_i) grant_o = rr_ptr_i ? 2'b10 : 2'b01;
    rr_ptr_nxt_o = rr_ptr_i;
    if (accept_i && (|grant_o)) rr_ptr_nxt_o = ~grant_o[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin into an operand register (S1),
// ALU between S1 and a result register (S2), tagged response handshake out of S2.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic [FLAG_W-1:0] rsp_flags
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [1:0]        grant;
  logic              advance, s1_free, accept;
  logic [DATA_W-1:0] alu_out;
  logic [FLAG_W-1:0] alu_flags;

  assign advance    = ~s2_valid_q | rsp_ready;
  assign s1_free    = ~s1_valid_q | advance;
  assign accept     = rst_n & s1_free & (|grant);
  assign req0_ready = rst_n & s1_free & grant[0];
  assign req1_ready = rst_n & s1_free & grant[1];

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .rr_ptr_i     (rr_ptr_q),
    .accept_i     (accept),
    .grant_o      (grant),
    .rr_ptr_nxt_o (rr_ptr_d)
  );

  alu u_alu (
    .out   (alu_out),
    .flags (alu_flags),
    .a     (s1_q.a),
    .b     (s1_q.b),
    .op    (s1_q.op)
  );

  // S1 empties when it drains into S2 and refills from the granted requester in the same cycle
  always_comb begin
    s1_valid_d = s1_valid_q & ~advance;
    s1_d       = s1_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = grant[1] ? '{id: REQ_ADDR, a: req1_a, b: req1_b, op: req1_op}
                            : '{id: REQ_EXEC, a: req0_a, b: req0_b, op: req0_op};
    end
  end

  // S2 captures the ALU result of S1 whenever the consumer is not stalling it
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_d       = '{id: s1_q.id, out: alu_out, flags: alu_flags};
    end
  end

  // Pipeline and pointer state; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      rr_ptr_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_q.id;
  assign rsp_out   = s2_q.out;
  assign rsp_flags = s2_q.flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of ALU vectors plus handshake/arbitration sequences, scoreboard-checked.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OP_W-1:0]   req0_op = '0, req1_op = '0;
  logic              rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [DATA_W-1:0] rsp_out;
  logic [FLAG_W-1:0] rsp_flags;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic id; logic [31:0] out; logic [6:0] flags; } exp_t;
  typedef struct { logic id; int cyc; } acc_t;
  typedef struct { logic [3:0] op; logic [31:0] a, b, eo; logic [6:0] ef; } vec_t;

  exp_t sb[$];
  acc_t acc[$];
  vec_t tbl[10];
  int   errs = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] o;
    logic [6:0]  f;
    s    = {1'b0, a} + {1'b0, b};
    o    = s[31:0];
    f[0] = s[32];
    f[1] = (o == 32'd0);
    f[2] = o[31];
    f[3] = (a[31] == b[31]) && (o[31] != a[31]);
    f[4] = ~^o[7:0];
    f[5] = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
    f[6] = (a == b);
    return {o, f};
  endfunction

  // Response checker: every completed response must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL rsp_unexpected: got id=%0d out=%h, expected no response", rsp_id, rsp_out);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_out", rsp_out, e.out);
        chk("rsp_flags", rsp_flags, e.flags);
      end
    end
  end

  // Present one op on a port, wait (bounded) for acceptance, record the expectation at the accepting edge
  task automatic send(input logic p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] eo, input logic [6:0] ef);
    bit got = 0;
    if (!p) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else    begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = p ? (req1_ready === 1'b1) : (req0_ready === 1'b1);
    end
    if (got) begin
      @(posedge clk);
      sb.push_back('{id: p, out: eo, flags: ef});
      acc.push_back('{id: p, cyc: cyc});
    end else begin
      checks++; errs++;
      $display("FAIL send_timeout: port %0d ready stayed 0, expected 1 within 60 cycles", p);
    end
    #1;
    if (!p) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic send_add(input logic p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] eo);
    logic [38:0] r;
    r = ref_add(a, b);
    send(p, a, b, ALU_OP_ADD, eo, r[6:0]);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    chk(name, sb.size(), 0);
    @(negedge clk);
    chk({name, "_idle"}, rsp_valid, 0);
  endtask

  // Assert reset (called just after a rising edge), check outputs, then release on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{ALU_OP_ADD, 32'hffffffff, 32'h00000000, 32'hffffffff, 7'h14};
    tbl[1] = '{ALU_OP_ADD, 32'hffffffff, 32'h00000001, 32'h00000000, 7'h33};
    tbl[2] = '{ALU_OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 7'h52};
    tbl[3] = '{ALU_OP_SUB, 32'h00000000, 32'h00000001, 32'hffffffff, 7'h35};
    tbl[4] = '{ALU_OP_AND, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 7'h14};
    tbl[5] = '{ALU_OP_XOR, 32'h12345678, 32'h12345678, 32'h00000000, 7'h52};
    tbl[6] = '{ALU_OP_SHL, 32'h00000001, 32'h0000001f, 32'h80000000, 7'h14};
    tbl[7] = '{ALU_OP_ADD, 32'h7fffffff, 32'h00000001, 32'h80000000, 7'h3c};
    tbl[8] = '{ALU_OP_OR,  32'h00000003, 32'h0000000c, 32'h0000000f, 7'h10};
    tbl[9] = '{ALU_OP_SHR, 32'h80000000, 32'h00000004, 32'h08000000, 7'h10};

    // Power-on reset
    #2;
    @(posedge clk); #1;
    do_reset();
    @(posedge clk); #1;

    // Single op from requester 0: result visible one cycle after it sits in S1
    send(0, 32'hffffffff, 32'h0, ALU_OP_ADD, 32'hffffffff, 7'h14);
    @(negedge clk);
    chk("lat_s1_only", rsp_valid, 0);
    @(negedge clk);
    chk("lat_rsp_valid", rsp_valid, 1);
    chk("lat_rsp_out", rsp_out, 32'hffffffff);
    chk("lat_rsp_id", rsp_id, 0);
    wait_drain("drain_single");

    // Table of opcode vectors, back to back on requester 0
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send(0, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].eo, tbl[i].ef);
    wait_drain("drain_table");

    // Stall: hold the result, S1 fills once, then both requesters are blocked
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_add(0, 32'h96579657, 32'h34563456, 32'hcaadcaad);
    fork
      send_add(1, 32'h11111111, 32'h22222222, 32'h33333333);
      send_add(0, 32'h01010101, 32'h02020202, 32'h03030303);
      begin
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_valid", rsp_valid, 1);
          chk("stall_out", rsp_out, 32'hcaadcaad);
          chk("stall_id", rsp_id, 0);
          chk("stall_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");

    // Reset with S1 and S2 both occupied; nothing stale may come out afterwards
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_add(0, 32'h00000010, 32'h00000020, 32'h00000030);
    send_add(0, 32'h00000040, 32'h00000050, 32'h00000090);
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end

    // Both requesters saturated: pointer restarts at 0, grants alternate every cycle
    @(posedge clk); #1;
    acc.delete();
    fork
      repeat (4) send_add(0, 32'ha47ba47b, 32'h5c915c91, 32'h010d010c);
      repeat (4) send_add(1, 32'hbcdabcda, 32'h79867986, 32'h36613660);
    join
    chk("alt_cnt", acc.size(), 8);
    for (int i = 0; i < 8 && i < acc.size(); i++) begin
      chk("alt_id", acc[i].id, i % 2);
      if (i > 0) chk("alt_cyc", acc[i].cyc - acc[i-1].cyc, 1);
    end
    wait_drain("drain_alt");

    // Requester 1 alone at full rate
    @(posedge clk); #1;
    acc.delete();
    for (int k = 0; k < 4; k++) begin
      logic [38:0] r;
      r = ref_add(32'h10000001 * (k + 1), 32'h0f00f00f);
      send(1, 32'h10000001 * (k + 1), 32'h0f00f00f, ALU_OP_ADD, r[38:7], r[6:0]);
    end
    chk("b2b_cnt", acc.size(), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      chk("b2b_id", acc[i].id, 1);
      if (i > 0) chk("b2b_cyc", acc[i].cyc - acc[i-1].cyc, 1);
    end
    wait_drain("drain_b2b");

    // Requester 0 joining a requester 1 burst wins the first tie
    @(posedge clk); #1;
    acc.delete();
    fork
      for (int k = 0; k < 4; k++) send_add(1, 32'h00000100 + k, 32'h00000001, 32'h00000101 + k);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_add(0, 32'h80000000, 32'h80000000, 32'h00000000);
      end
    join
    chk("mid_cnt", acc.size(), 5);
    for (int i = 0; i < 5 && i < acc.size(); i++) chk("mid_id", acc[i].id, (i == 2) ? 0 : 1);
    wait_drain("drain_mid");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
